// File: rtl/uart_rxfifo_pkg.sv
// Shared UART receive-entry layout and RTS state encoding, used by the rx FIFO
// and by the bus-side status register decode.
package uart_rxfifo_pkg;

  localparam int UART_ENTRY_W  = 10;
  localparam int UART_PERR_BIT = 8;
  localparam int UART_FERR_BIT = 9;

  typedef enum logic {
    RTS_GO   = 1'b0,
    RTS_STOP = 1'b1
  } rts_state_t;

  function automatic logic [UART_ENTRY_W-1:0] uart_pack_entry(
    input logic       ferr,
    input logic       perr,
    input logic [7:0] data
  );
    return {ferr, perr, data};
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// Register array for the rx FIFO: synchronous write, asynchronous read so the
// head entry falls through without an extra cycle.
module sfifo_mem #(
  parameter int LGFLEN = 4,
  parameter int WIDTH  = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [LGFLEN-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [LGFLEN-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [2**LGFLEN];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rxfifo.sv
// UART receive FIFO: buffers bytes with parity/frame flags, presents the head
// first-word-fall-through, and drives RTS with fill-level hysteresis.
module uart_rxfifo
  import uart_rxfifo_pkg::*;
#(
  parameter int LGFLEN = 4,
  parameter int RTS_HI = 12,
  parameter int RTS_LO = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_rx_stb,
  input  logic [7:0]      i_rx_data,
  input  logic            i_rx_perr,
  input  logic            i_rx_ferr,
  input  logic            i_rx_break,
  input  logic            i_rd,
  input  logic            i_clr,
  output logic            o_empty_n,
  output logic [7:0]      o_data,
  output logic            o_perr,
  output logic            o_ferr,
  output logic [LGFLEN:0] o_fill,
  output logic            o_ovfl,
  output logic            o_break,
  output logic            o_half_int,
  output logic            o_uart_rts_n
);

  localparam int PW = LGFLEN + 1;
  localparam logic [LGFLEN:0] HALF_LVL = PW'(2**(LGFLEN-1));
  localparam logic [LGFLEN:0] HI_LVL   = PW'(RTS_HI);
  localparam logic [LGFLEN:0] LO_LVL   = PW'(RTS_LO);

  logic [LGFLEN:0]         r_wr, r_rd;
  logic [LGFLEN:0]         w_wr_next, w_rd_next, w_fill_next;
  logic                    w_empty, w_full, w_pop, w_push;
  logic                    w_ovfl_set, w_break_set;
  logic                    r_ovfl, r_break, r_break_d, r_half;
  logic [UART_ENTRY_W-1:0] w_wdata, w_rdata;
  rts_state_t              r_rts_state, w_rts_next;

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[LGFLEN-1:0] == r_rd[LGFLEN-1:0]) && (r_wr[LGFLEN] != r_rd[LGFLEN]);
  assign w_pop   = i_rd && !w_empty;
  // A full FIFO still accepts a byte when the same cycle frees a slot.
  assign w_push      = i_rx_stb && !i_rx_break && (!w_full || w_pop);
  assign w_ovfl_set  = i_rx_stb && !i_rx_break && w_full && !w_pop;
  assign w_break_set = i_rx_break && !r_break_d;

  assign w_wr_next   = w_push ? r_wr + 1'b1 : r_wr;
  assign w_rd_next   = w_pop  ? r_rd + 1'b1 : r_rd;
  assign w_fill_next = w_wr_next - w_rd_next;
  assign w_wdata     = uart_pack_entry(i_rx_ferr, i_rx_perr, i_rx_data);

  sfifo_mem #(
    .LGFLEN (LGFLEN),
    .WIDTH  (UART_ENTRY_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_push),
    .i_waddr (r_wr[LGFLEN-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (r_rd[LGFLEN-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_ovfl      <= 1'b0;
      r_break     <= 1'b0;
      r_break_d   <= 1'b0;
      r_half      <= 1'b0;
      r_rts_state <= RTS_GO;
    end else begin
      r_wr        <= w_wr_next;
      r_rd        <= w_rd_next;
      r_break_d   <= i_rx_break;
      r_half      <= (w_fill_next >= HALF_LVL);
      r_rts_state <= w_rts_next;
      // Set has priority over clear so a same-cycle event is never lost.
      if (w_ovfl_set)  r_ovfl <= 1'b1;
      else if (i_clr)  r_ovfl <= 1'b0;
      if (w_break_set) r_break <= 1'b1;
      else if (i_clr)  r_break <= 1'b0;
    end
  end

  always_comb begin
    w_rts_next = r_rts_state;
    case (r_rts_state)
      RTS_GO:   if (w_fill_next >= HI_LVL) w_rts_next = RTS_STOP;
      RTS_STOP: if (w_fill_next <= LO_LVL) w_rts_next = RTS_GO;
      default:  w_rts_next = RTS_GO;
    endcase
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign o_empty_n    = !w_empty;
  assign o_data       = w_empty ? 8'h00 : w_rdata[7:0];
  assign o_perr       = !w_empty && w_rdata[UART_PERR_BIT];
  assign o_ferr       = !w_empty && w_rdata[UART_FERR_BIT];
  assign o_fill       = r_wr - r_rd;
  assign o_ovfl       = r_ovfl;
  assign o_break      = r_break;
  assign o_half_int   = r_half;
  assign o_uart_rts_n = (r_rts_state == RTS_STOP);

endmodule

// File: tb/tb_uart_rxfifo.sv
// Directed self-checking bench for uart_rxfifo (16 entries, RTS 12/4).
module tb_uart_rxfifo;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_rx_stb = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_perr = 1'b0;
  logic       i_rx_ferr = 1'b0;
  logic       i_rx_break = 1'b0;
  logic       i_rd = 1'b0;
  logic       i_clr = 1'b0;
  logic       o_empty_n;
  logic [7:0] o_data;
  logic       o_perr;
  logic       o_ferr;
  logic [4:0] o_fill;
  logic       o_ovfl;
  logic       o_break;
  logic       o_half_int;
  logic       o_uart_rts_n;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rxfifo #(.LGFLEN(4), .RTS_HI(12), .RTS_LO(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx_stb     (i_rx_stb),
    .i_rx_data    (i_rx_data),
    .i_rx_perr    (i_rx_perr),
    .i_rx_ferr    (i_rx_ferr),
    .i_rx_break   (i_rx_break),
    .i_rd         (i_rd),
    .i_clr        (i_clr),
    .o_empty_n    (o_empty_n),
    .o_data       (o_data),
    .o_perr       (o_perr),
    .o_ferr       (o_ferr),
    .o_fill       (o_fill),
    .o_ovfl       (o_ovfl),
    .o_break      (o_break),
    .o_half_int   (o_half_int),
    .o_uart_rts_n (o_uart_rts_n)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock with the given inputs, then back to idle; outputs are read 1 ns after the edge.
  task automatic cyc(input logic stb, input logic [7:0] d, input logic perr, input logic ferr,
                     input logic brk, input logic rd, input logic clr);
    i_rx_stb = stb; i_rx_data = d; i_rx_perr = perr; i_rx_ferr = ferr;
    i_rx_break = brk; i_rd = rd; i_clr = clr;
    @(posedge i_clk); #1;
    i_rx_stb = 0; i_rx_data = 8'h00; i_rx_perr = 0; i_rx_ferr = 0;
    i_rx_break = 0; i_rd = 0; i_clr = 0;
    $display("[TB] t=%0t stb=%b d=%h brk=%b rd=%b clr=%b -> empty_n=%b data=%h fill=%0d ovfl=%b brk=%b half=%b rts_n=%b",
             $time, stb, d, brk, rd, clr, o_empty_n, o_data, o_fill, o_ovfl, o_break, o_half_int, o_uart_rts_n);
  endtask

  task automatic apply_reset();
    i_rst_n = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (o_empty_n !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_empty_n got=%b exp=0", o_empty_n); end
    n_tests++; if (o_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data got=%h exp=00", o_data); end
    n_tests++; if (o_fill !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_fill got=%0d exp=0", o_fill); end
    n_tests++; if ({o_ovfl, o_break, o_half_int, o_uart_rts_n, o_perr, o_ferr} !== 6'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags got=%b exp=000000", {o_ovfl, o_break, o_half_int, o_uart_rts_n, o_perr, o_ferr});
    end
  endtask

  task automatic test_single();
    cyc(1, 8'h41, 0, 0, 0, 0, 0);
    n_tests++; if (o_empty_n !== 1'b1) begin n_fail++; $display("[TB] FAIL single_empty_n got=%b exp=1", o_empty_n); end
    n_tests++; if (o_data !== 8'h41) begin n_fail++; $display("[TB] FAIL single_data got=%h exp=41", o_data); end
    n_tests++; if (o_fill !== 5'd1) begin n_fail++; $display("[TB] FAIL single_fill got=%0d exp=1", o_fill); end
    cyc(0, 8'h00, 0, 0, 0, 1, 0);
    n_tests++; if (o_empty_n !== 1'b0) begin n_fail++; $display("[TB] FAIL single_pop_empty_n got=%b exp=0", o_empty_n); end
    n_tests++; if (o_fill !== 5'd0) begin n_fail++; $display("[TB] FAIL single_pop_fill got=%0d exp=0", o_fill); end
    // Pop on empty is ignored; push+pop on empty keeps only the push.
    cyc(0, 8'h00, 0, 0, 0, 1, 0);
    n_tests++; if (o_fill !== 5'd0) begin n_fail++; $display("[TB] FAIL empty_pop_fill got=%0d exp=0", o_fill); end
    cyc(1, 8'h33, 0, 0, 0, 1, 0);
    n_tests++; if (o_fill !== 5'd1 || o_data !== 8'h33) begin
      n_fail++; $display("[TB] FAIL empty_pushpop got fill=%0d data=%h exp fill=1 data=33", o_fill, o_data);
    end
    cyc(0, 8'h00, 0, 0, 0, 1, 0);
  endtask

  // Fill to 16, drain 12 checking order, hysteresis and half-full, then refill to full.
  task automatic test_fill_rts();
    logic exp_rts = 1'b0;
    int   f;
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 0, 0, 0, 0, 0);
      f = i + 1;
      if (f >= 12) exp_rts = 1'b1;
      n_tests++; if (o_fill !== 5'(f)) begin n_fail++; $display("[TB] FAIL fill_up_%0d got=%0d exp=%0d", i, o_fill, f); end
      n_tests++; if (o_half_int !== (f >= 8)) begin n_fail++; $display("[TB] FAIL half_up_%0d got=%b exp=%b", i, o_half_int, f >= 8); end
      n_tests++; if (o_uart_rts_n !== exp_rts) begin n_fail++; $display("[TB] FAIL rts_up_%0d got=%b exp=%b", i, o_uart_rts_n, exp_rts); end
    end
    for (int i = 0; i < 12; i++) begin
      n_tests++; if (o_data !== 8'(i)) begin n_fail++; $display("[TB] FAIL drain_data_%0d got=%h exp=%h", i, o_data, 8'(i)); end
      cyc(0, 8'h00, 0, 0, 0, 1, 0);
      f = 15 - i;
      if (f <= 4) exp_rts = 1'b0;
      n_tests++; if (o_fill !== 5'(f)) begin n_fail++; $display("[TB] FAIL fill_dn_%0d got=%0d exp=%0d", i, o_fill, f); end
      n_tests++; if (o_half_int !== (f >= 8)) begin n_fail++; $display("[TB] FAIL half_dn_%0d got=%b exp=%b", i, o_half_int, f >= 8); end
      n_tests++; if (o_uart_rts_n !== exp_rts) begin n_fail++; $display("[TB] FAIL rts_dn_%0d got=%b exp=%b", i, o_uart_rts_n, exp_rts); end
    end
    for (int i = 0; i < 12; i++) cyc(1, 8'(16 + i), 0, 0, 0, 0, 0);
    n_tests++; if (o_fill !== 5'd16) begin n_fail++; $display("[TB] FAIL refill_fill got=%0d exp=16", o_fill); end
  endtask

  task automatic test_overflow();
    cyc(1, 8'hAA, 0, 0, 0, 0, 0);
    n_tests++; if (o_ovfl !== 1'b1) begin n_fail++; $display("[TB] FAIL ovfl_set got=%b exp=1", o_ovfl); end
    n_tests++; if (o_fill !== 5'd16) begin n_fail++; $display("[TB] FAIL ovfl_fill got=%0d exp=16", o_fill); end
    n_tests++; if (o_data !== 8'h0C) begin n_fail++; $display("[TB] FAIL ovfl_head got=%h exp=0c", o_data); end
    cyc(0, 8'h00, 0, 0, 0, 0, 1);
    n_tests++; if (o_ovfl !== 1'b0) begin n_fail++; $display("[TB] FAIL ovfl_clr got=%b exp=0", o_ovfl); end
    cyc(1, 8'hAB, 0, 0, 0, 0, 1);
    n_tests++; if (o_ovfl !== 1'b1) begin n_fail++; $display("[TB] FAIL ovfl_set_wins got=%b exp=1", o_ovfl); end
    cyc(0, 8'h00, 0, 0, 0, 0, 1);
  endtask

  task automatic test_full_push_pop();
    logic [7:0] last = 8'h00;
    cyc(1, 8'h55, 0, 0, 0, 1, 0);
    n_tests++; if (o_fill !== 5'd16) begin n_fail++; $display("[TB] FAIL fullpp_fill got=%0d exp=16", o_fill); end
    n_tests++; if (o_ovfl !== 1'b0) begin n_fail++; $display("[TB] FAIL fullpp_ovfl got=%b exp=0", o_ovfl); end
    n_tests++; if (o_data !== 8'h0D) begin n_fail++; $display("[TB] FAIL fullpp_head got=%h exp=0d", o_data); end
    for (int i = 0; i < 16; i++) begin
      last = o_data;
      cyc(0, 8'h00, 0, 0, 0, 1, 0);
    end
    n_tests++; if (last !== 8'h55) begin n_fail++; $display("[TB] FAIL fullpp_last got=%h exp=55", last); end
    n_tests++; if (o_empty_n !== 1'b0) begin n_fail++; $display("[TB] FAIL fullpp_drained got=%b exp=0", o_empty_n); end
  endtask

  task automatic test_flags();
    cyc(1, 8'h7E, 1, 1, 0, 0, 0);
    n_tests++; if ({o_perr, o_ferr, o_data} !== {2'b11, 8'h7E}) begin
      n_fail++; $display("[TB] FAIL flags_head got=%b%b/%h exp=11/7e", o_perr, o_ferr, o_data);
    end
    cyc(1, 8'h11, 0, 0, 1, 0, 0);
    n_tests++; if (o_fill !== 5'd1) begin n_fail++; $display("[TB] FAIL break_nopush got=%0d exp=1", o_fill); end
    n_tests++; if (o_break !== 1'b1) begin n_fail++; $display("[TB] FAIL break_set got=%b exp=1", o_break); end
    cyc(0, 8'h00, 0, 0, 0, 1, 0);
    n_tests++; if (o_break !== 1'b1 || o_empty_n !== 1'b0) begin
      n_fail++; $display("[TB] FAIL break_sticky got brk=%b empty_n=%b exp brk=1 empty_n=0", o_break, o_empty_n);
    end
    cyc(0, 8'h00, 0, 0, 0, 0, 1);
    n_tests++; if (o_break !== 1'b0) begin n_fail++; $display("[TB] FAIL break_clr got=%b exp=0", o_break); end
  endtask

  task automatic test_wrap_reset();
    apply_reset();
    for (int k = 0; k < 40; k++) begin
      cyc(1, 8'(8'h80 + k), 0, 0, 0, 0, 0);
      n_tests++; if (o_data !== 8'(8'h80 + k)) begin n_fail++; $display("[TB] FAIL wrap_data_%0d got=%h exp=%h", k, o_data, 8'(8'h80 + k)); end
      cyc(0, 8'h00, 0, 0, 0, 1, 0);
    end
    for (int k = 0; k < 5; k++) cyc(1, 8'(8'hC0 + k), 0, 0, 0, 0, 0);
    n_tests++; if (o_fill !== 5'd5 || o_data !== 8'hC0) begin
      n_fail++; $display("[TB] FAIL wrap_fill got fill=%0d head=%h exp fill=5 head=c0", o_fill, o_data);
    end
    #2 i_rst_n = 0;
    #1;
    n_tests++; if ({o_empty_n, o_data, o_fill, o_ovfl, o_break, o_half_int, o_uart_rts_n} !== 18'd0) begin
      n_fail++; $display("[TB] FAIL async_reset got empty_n=%b data=%h fill=%0d exp all zero", o_empty_n, o_data, o_fill);
    end
    @(posedge i_clk); #1 i_rst_n = 1;
    cyc(0, 8'h00, 0, 0, 0, 0, 0);
    n_tests++; if (o_fill !== 5'd0 || o_empty_n !== 1'b0) begin
      n_fail++; $display("[TB] FAIL post_reset got fill=%0d empty_n=%b exp 0/0", o_fill, o_empty_n);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_rts();
    test_overflow();
    test_full_push_pop();
    test_flags();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
